// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared types and constants for the HD44780 bus write sequencer.
// Default timings assume a 50 MHz clock.
package lcd_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_EXEC
  } state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam int DEF_T_SETUP     = 2;
  localparam int DEF_T_EN        = 25;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_EXEC      = 2000;
  localparam int DEF_T_EXEC_LONG = 80000;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == CMD_CLEAR) || ({d[7:1], 1'b0} == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_bus_sequencer_if.sv
// Requester handshake plus LCD pin bundle for the bus sequencer.
interface lcd_bus_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_nibble_only;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;

  modport master (
    output in_valid, in_rs, in_data, in_nibble_only,
    input  in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, busy
  );

  modport slave (
    input  in_valid, in_rs, in_data, in_nibble_only,
    output in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, busy
  );
endinterface

// File: rtl/lcd_bus_sequencer_delay_timer.sv
// Loadable down-counter shared by every sequencer phase; done while it sits at 0.
module lcd_delay_timer #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = value_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Single-byte HD44780 write sequencer: SETUP/ENABLE/HOLD per transfer (two in
// 4-bit mode), then an execution wait before the next byte is accepted.
module lcd_bus_sequencer
  import lcd_bus_sequencer_pkg::*;
#(
  parameter bit FOUR_BIT    = 1'b1,
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_EN        = DEF_T_EN,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_EXEC      = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  lcd_bus_sequencer_if.slave bus
);

  localparam int T_MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int T_MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;
  localparam int CW      = $clog2(T_MAX) + 1;

  state_e        state_q, state_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          nib_only_q, nib_only_d;
  logic          nib_lo_q, nib_lo_d;
  logic          lcd_e_q, lcd_e_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_db_q, lcd_db_d;
  logic          accept;
  logic          tmr_load, tmr_done;
  logic [CW-1:0] tmr_val;
  logic [3:0]    nib;

  lcd_delay_timer #(.CW(CW)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .done_o  (tmr_done)
  );

  assign accept     = (state_q == ST_IDLE) && bus.in_valid;
  assign rs_d       = accept ? bus.in_rs : rs_q;
  assign data_d     = accept ? bus.in_data : data_q;
  assign nib_only_d = accept ? (bus.in_nibble_only && FOUR_BIT) : nib_only_q;

  always_comb begin
    state_d  = state_q;
    nib_lo_d = nib_lo_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d  = ST_SETUP;
        nib_lo_d = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = CW'(T_SETUP - 1);
      end
      ST_SETUP: if (tmr_done) begin
        state_d  = ST_ENABLE;
        tmr_load = 1'b1;
        tmr_val  = CW'(T_EN - 1);
      end
      ST_ENABLE: if (tmr_done) begin
        state_d  = ST_HOLD;
        tmr_load = 1'b1;
        tmr_val  = CW'(T_HOLD - 1);
      end
      ST_HOLD: if (tmr_done) begin
        tmr_load = 1'b1;
        if (FOUR_BIT && !nib_lo_q && !nib_only_q) begin
          state_d  = ST_SETUP;
          nib_lo_d = 1'b1;
          tmr_val  = CW'(T_SETUP - 1);
        end else begin
          state_d  = ST_EXEC;
          tmr_val  = is_long_cmd(rs_q, data_q) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        end
      end
      ST_EXEC: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin registers are computed from the next state so they line up with state_q.
  assign nib = nib_lo_d ? data_d[3:0] : data_d[7:4];

  always_comb begin
    lcd_e_d  = (state_d == ST_ENABLE);
    lcd_rs_d = lcd_rs_q;
    lcd_db_d = lcd_db_q;
    if (state_d == ST_SETUP) begin
      lcd_rs_d = rs_d;
      lcd_db_d = FOUR_BIT ? {nib, 4'h0} : data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      nib_only_q <= 1'b0;
      nib_lo_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_db_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      nib_only_q <= nib_only_d;
      nib_lo_q   <= nib_lo_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_db_q   <= lcd_db_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.lcd_e    = lcd_e_q;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_db   = lcd_db_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench: one 4-bit and one 8-bit sequencer share clock and reset.
module tb_lcd_bus_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lcd_bus_sequencer_if b4 ();
  lcd_bus_sequencer_if b8 ();

  lcd_bus_sequencer #(.FOUR_BIT(1'b1), .T_SETUP(2), .T_EN(3), .T_HOLD(1),
                      .T_EXEC(5), .T_EXEC_LONG(9))
    u4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4));

  lcd_bus_sequencer #(.FOUR_BIT(1'b0), .T_SETUP(2), .T_EN(3), .T_HOLD(1),
                      .T_EXEC(5), .T_EXEC_LONG(9))
    u8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8));

  task automatic drive(input bit sel, input bit v, input bit rs, input logic [7:0] d, input bit nib);
    if (sel) begin
      b4.in_valid = v; b4.in_rs = rs; b4.in_data = d; b4.in_nibble_only = nib;
    end else begin
      b8.in_valid = v; b8.in_rs = rs; b8.in_data = d; b8.in_nibble_only = nib;
    end
  endtask

  // Issues one byte and records what the pins did until busy falls again.
  task automatic xfer(input bit sel, input bit rs, input logic [7:0] d, input bit nib,
                      output int blen, output int np, output int el0, output int el1,
                      output logic [7:0] db0, output logic [7:0] db1,
                      output bit rs_bad, output bit rdy_bad, output bit tout);
    bit pe, seen;
    logic e, b, lrs, rd;
    logic [7:0] db;
    blen = 0; np = 0; el0 = 0; el1 = 0; db0 = 8'h00; db1 = 8'h00;
    rs_bad = 1'b0; rdy_bad = 1'b0; tout = 1'b1; pe = 1'b0; seen = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, rs, d, nib);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
      e   = sel ? b4.lcd_e    : b8.lcd_e;
      b   = sel ? b4.busy     : b8.busy;
      lrs = sel ? b4.lcd_rs   : b8.lcd_rs;
      rd  = sel ? b4.in_ready : b8.in_ready;
      db  = sel ? b4.lcd_db   : b8.lcd_db;
      if (b) begin
        seen = 1'b1;
        blen++;
        if (lrs !== rs) rs_bad = 1'b1;
        if (rd !== 1'b0) rdy_bad = 1'b1;
        if (e && !pe) begin
          np++;
          if (np == 1) db0 = db; else db1 = db;
        end
        if (e) begin
          if (np == 1) el0++; else el1++;
        end
      end else if (seen) begin
        if (rd !== 1'b1) rdy_bad = 1'b1;
        tout = 1'b0;
        break;
      end
      pe = e;
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #12;
    tests++; if ({b4.lcd_e, b4.lcd_rs, b4.lcd_rw, b4.busy, b4.in_ready} !== 5'b00001) begin
      fails++; $display("FAIL reset4_ctl: got %b want 00001", {b4.lcd_e, b4.lcd_rs, b4.lcd_rw, b4.busy, b4.in_ready}); end
    tests++; if (b4.lcd_db !== 8'h00) begin fails++; $display("FAIL reset4_db: got %h want 00", b4.lcd_db); end
    tests++; if ({b8.lcd_e, b8.lcd_rs, b8.lcd_rw, b8.busy, b8.in_ready, b8.lcd_db} !== {5'b00001, 8'h00}) begin
      fails++; $display("FAIL reset8: got %b want 0000100000000", {b8.lcd_e, b8.lcd_rs, b8.lcd_rw, b8.busy, b8.in_ready, b8.lcd_db}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_four_bit_data();
    int blen, np, el0, el1; logic [7:0] db0, db1; bit rsb, rdb, to;
    xfer(1'b1, 1'b1, 8'h48, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to) begin fails++; $display("FAIL w48_timeout: got 1 want 0"); end
    tests++; if (blen !== 17) begin fails++; $display("FAIL w48_busy: got %0d want 17", blen); end
    tests++; if (np !== 2) begin fails++; $display("FAIL w48_pulses: got %0d want 2", np); end
    tests++; if (el0 !== 3 || el1 !== 3) begin fails++; $display("FAIL w48_elen: got %0d/%0d want 3/3", el0, el1); end
    tests++; if (db0 !== 8'h40 || db1 !== 8'h80) begin fails++; $display("FAIL w48_db: got %h/%h want 40/80", db0, db1); end
    tests++; if (rsb) begin fails++; $display("FAIL w48_rs: got 0 want 1 during busy"); end
    tests++; if (rdb) begin fails++; $display("FAIL w48_ready: got wrong in_ready want 0 busy/1 after"); end
  endtask

  task automatic test_long_exec();
    int blen, np, el0, el1; logic [7:0] db0, db1; bit rsb, rdb, to;
    xfer(1'b1, 1'b0, 8'h01, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 21) begin fails++; $display("FAIL clear_busy: got %0d want 21", blen); end
    tests++; if (np !== 2 || db0 !== 8'h00 || db1 !== 8'h10) begin
      fails++; $display("FAIL clear_db: got %0d pulses %h/%h want 2 pulses 00/10", np, db0, db1); end
    tests++; if (rdb) begin fails++; $display("FAIL clear_ready: got wrong in_ready want 0 busy/1 after"); end
    xfer(1'b1, 1'b0, 8'h03, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 21) begin fails++; $display("FAIL home3_busy: got %0d want 21", blen); end
    xfer(1'b1, 1'b0, 8'h04, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 17) begin fails++; $display("FAIL cmd04_busy: got %0d want 17", blen); end
    xfer(1'b1, 1'b0, 8'h00, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 17) begin fails++; $display("FAIL cmd00_busy: got %0d want 17", blen); end
    xfer(1'b1, 1'b1, 8'h01, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 17) begin fails++; $display("FAIL data01_busy: got %0d want 17", blen); end
  endtask

  task automatic test_nibble_only();
    int blen, np, el0, el1; logic [7:0] db0, db1; bit rsb, rdb, to;
    xfer(1'b1, 1'b0, 8'h30, 1'b1, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 11) begin fails++; $display("FAIL nib_busy: got %0d want 11", blen); end
    tests++; if (np !== 1 || el0 !== 3) begin fails++; $display("FAIL nib_pulse: got %0d pulses len %0d want 1 len 3", np, el0); end
    tests++; if (db0 !== 8'h30) begin fails++; $display("FAIL nib_db: got %h want 30", db0); end
  endtask

  task automatic test_eight_bit();
    int blen, np, el0, el1; logic [7:0] db0, db1; bit rsb, rdb, to;
    xfer(1'b0, 1'b0, 8'h38, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 11) begin fails++; $display("FAIL w8_busy: got %0d want 11", blen); end
    tests++; if (np !== 1 || el0 !== 3 || db0 !== 8'h38) begin
      fails++; $display("FAIL w8_pulse: got %0d pulses len %0d db %h want 1 len 3 db 38", np, el0, db0); end
    xfer(1'b0, 1'b0, 8'h38, 1'b1, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 11 || db0 !== 8'h38) begin
      fails++; $display("FAIL w8_nibign: got busy %0d db %h want 11 38", blen, db0); end
    xfer(1'b0, 1'b0, 8'h02, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 15) begin fails++; $display("FAIL w8_home: got %0d want 15", blen); end
  endtask

  task automatic test_reset_mid_enable();
    int blen, np, el0, el1; logic [7:0] db0, db1; bit rsb, rdb, to, hit;
    hit = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 8'h48, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (b4.lcd_e === 1'b1) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!hit) begin fails++; $display("FAIL rst_mid_reach: got no E pulse want E high"); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (b4.lcd_e !== 1'b0 || b4.busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_async: got e=%b busy=%b want 0 0", b4.lcd_e, b4.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (b4.in_ready !== 1'b1 || b4.busy !== 1'b0 || b4.lcd_db !== 8'h00) begin
      fails++; $display("FAIL rst_mid_idle: got ready=%b busy=%b db=%h want 1 0 00", b4.in_ready, b4.busy, b4.lcd_db); end
    xfer(1'b1, 1'b1, 8'h48, 1'b0, blen, np, el0, el1, db0, db1, rsb, rdb, to);
    tests++; if (to || blen !== 17 || np !== 2 || db1 !== 8'h80) begin
      fails++; $display("FAIL rst_mid_clean: got busy %0d pulses %0d db1 %h want 17 2 80", blen, np, db1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [3:0] nibs [6];
    int acc, busyc, np, lowrun, mingap, last;
    bit pe, done;
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    acc = 0; busyc = 0; np = 0; lowrun = 0; mingap = 999; last = -1; pe = 1'b0; done = 1'b0;
    for (int i = 0; i < 6; i++) nibs[i] = 4'h0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (b4.busy) busyc++;
      if (b4.lcd_e && !pe) begin
        if (np > 0 && lowrun < mingap) mingap = lowrun;
        if (np < 6) nibs[np] = b4.lcd_db[7:4];
        np++;
      end
      if (!b4.lcd_e) lowrun++; else lowrun = 0;
      if (b4.in_ready) begin
        if (acc < 3) begin
          drive(1'b1, 1'b1, 1'b1, bytes[acc], 1'b0);
          acc++;
        end else if (!b4.in_valid) begin
          done = 1'b1; last = c;
        end
      end else if (acc == 3) begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      pe = b4.lcd_e;
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tests++; if (last !== 54) begin fails++; $display("FAIL b2b_span: got %0d want 54", last); end
    tests++; if (busyc !== 51) begin fails++; $display("FAIL b2b_busy: got %0d want 51", busyc); end
    tests++; if (np !== 6) begin fails++; $display("FAIL b2b_pulses: got %0d want 6", np); end
    tests++; if (mingap !== 3) begin fails++; $display("FAIL b2b_gap: got %0d want 3", mingap); end
    tests++; if ({nibs[0], nibs[1], nibs[2], nibs[3], nibs[4], nibs[5]} !== 24'h414243) begin
      fails++; $display("FAIL b2b_nibs: got %h want 414243", {nibs[0], nibs[1], nibs[2], nibs[3], nibs[4], nibs[5]}); end
  endtask

  initial begin
    test_reset();
    test_four_bit_data();
    test_long_exec();
    test_nibble_only();
    test_eight_bit();
    test_reset_mid_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
